// File: rtl/eth_rgmii_rx_mr_if.sv
// Frame-side bus of the multi-rate RGMII receive framer: byte stream plus
// per-frame status, driven by the framer (master) into the MAC rx FIFO (slave).
interface eth_rgmii_rx_mr_if #(
    parameter int CNT_WIDTH = 16
);
    logic [7:0]           data;
    logic                 valid;
    logic                 sop;
    logic                 eop;
    logic                 crc_ok;
    logic                 len_err;
    logic                 err;
    logic [CNT_WIDTH-1:0] frame_len;

    modport master (
        output data, valid, sop, eop, crc_ok, len_err, err, frame_len
    );

    modport slave (
        input data, valid, sop, eop, crc_ok, len_err, err, frame_len
    );
endinterface

// File: rtl/eth_rgmii_rx_mr.sv
// Multi-rate (10/100/1000) RGMII receive framer: preamble/SFD detection, nibble
// assembly, CRC-32 residue and length checks, optional FCS strip, in-band link status.
module eth_rgmii_rx_mr #(
    parameter int MIN_LEN       = 64,
    parameter int MAX_LEN       = 1518,
    parameter int CNT_WIDTH     = 16,
    parameter int STRIP_FCS     = 0,
    parameter int INBAND_STATUS = 1
) (
    input  logic                rx_clk,
    input  logic                rst_n,
    input  logic [1:0]          speed,
    input  logic                rx_dv,
    input  logic                rx_err,
    input  logic [7:0]          rx_data,
    eth_rgmii_rx_mr_if.master   rx_out,
    output logic                link_up,
    output logic [1:0]          link_speed,
    output logic                link_fdx
);
    typedef enum logic [2:0] {
        ST_RESYNC   = 3'd0,
        ST_IDLE     = 3'd1,
        ST_PREAMBLE = 3'd2,
        ST_PACKET   = 3'd3,
        ST_DROP     = 3'd4
    } state_t;

    localparam logic [31:0]          CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [CNT_WIDTH-1:0] MIN_LEN_C   = CNT_WIDTH'(MIN_LEN);
    localparam logic [CNT_WIDTH-1:0] MAX_LEN_C   = CNT_WIDTH'(MAX_LEN);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Reflected Ethernet CRC-32 over one byte, LSB first, no final inversion.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if ((c[0] ^ d[i]) == 1'b1) begin
                c = (c >> 1) ^ 32'hEDB88320;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    state_t               state_q, state_d;
    logic                 mode_q, mode_d;          // 1 = nibble mode (10/100)
    logic                 nib_have_q, nib_have_d;
    logic [3:0]           nib_lo_q, nib_lo_d;
    logic [31:0]          crc_q, crc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic [3:0][7:0]      dl_q, dl_d;
    logic [2:0]           dl_cnt_q, dl_cnt_d;
    logic [7:0]           data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 sop_q, sop_d;
    logic                 eop_q, eop_d;
    logic                 crc_ok_q, crc_ok_d;
    logic                 len_err_q, len_err_d;
    logic                 err_out_q, err_out_d;
    logic [CNT_WIDTH-1:0] frame_len_q, frame_len_d;
    logic                 link_up_q, link_up_d;
    logic [1:0]           link_speed_q, link_speed_d;
    logic                 link_fdx_q, link_fdx_d;
    logic                 speed_nib_s;
    logic                 byte_done_s;
    logic [7:0]           byte_s;

    assign speed_nib_s = (speed == 2'b00) || (speed == 2'b01);

    // Next-state, byte assembly and output computation.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        nib_have_d   = nib_have_q;
        nib_lo_d     = nib_lo_q;
        crc_d        = crc_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        dl_d         = dl_q;
        dl_cnt_d     = dl_cnt_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        sop_d        = 1'b0;
        eop_d        = 1'b0;
        crc_ok_d     = crc_ok_q;
        len_err_d    = len_err_q;
        err_out_d    = err_out_q;
        frame_len_d  = frame_len_q;
        link_up_d    = link_up_q;
        link_speed_d = link_speed_q;
        link_fdx_d   = link_fdx_q;
        byte_done_s  = 1'b0;
        byte_s       = 8'h00;

        case (state_q)
            ST_RESYNC, ST_DROP: begin
                if (!rx_dv) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_IDLE: begin
                if (rx_dv) begin
                    if (speed_nib_s ? (rx_data[3:0] == 4'h5) : (rx_data == 8'h55)) begin
                        state_d    = ST_PREAMBLE;
                        sop_d      = 1'b1;
                        crc_d      = 32'hFFFFFFFF;
                        cnt_d      = {CNT_WIDTH{1'b0}};
                        err_d      = 1'b0;
                        nib_have_d = 1'b0;
                        dl_cnt_d   = 3'd0;
                        mode_d     = speed_nib_s;
                    end else begin
                        state_d = ST_DROP;
                    end
                end else if (!rx_err && (INBAND_STATUS != 0)) begin
                    link_up_d    = rx_data[0];
                    link_speed_d = rx_data[2:1];
                    link_fdx_d   = rx_data[3];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PREAMBLE: begin
                if (!rx_dv) begin
                    state_d = ST_IDLE;
                end else if (mode_q ? (rx_data[3:0] == 4'h5) : (rx_data == 8'h55)) begin
                    state_d = ST_PREAMBLE;
                end else if (mode_q ? (rx_data[3:0] == 4'hD) : (rx_data == 8'hD5)) begin
                    state_d = ST_PACKET;
                end else begin
                    state_d = ST_DROP;
                end
            end
            ST_PACKET: begin
                if (rx_dv) begin
                    err_d = err_q | rx_err;
                    if (!mode_q) begin
                        byte_s      = rx_data;
                        byte_done_s = 1'b1;
                    end else if (nib_have_q) begin
                        byte_s      = {rx_data[3:0], nib_lo_q};
                        byte_done_s = 1'b1;
                        nib_have_d  = 1'b0;
                    end else begin
                        nib_lo_d   = rx_data[3:0];
                        nib_have_d = 1'b1;
                    end
                end else begin
                    // A dangling low nibble is dropped but flagged as an error.
                    eop_d       = 1'b1;
                    crc_ok_d    = (crc_q == CRC_RESIDUE);
                    len_err_d   = (cnt_q < MIN_LEN_C) || (cnt_q > MAX_LEN_C);
                    err_out_d   = err_q | nib_have_q;
                    frame_len_d = cnt_q;
                    nib_have_d  = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_RESYNC;
            end
        endcase

        if (byte_done_s) begin
            crc_d = crc32_byte(crc_q, byte_s);
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
            if (STRIP_FCS != 0) begin
                // Bytes still in the delay line at eop are the FCS and are never shown.
                dl_d = {dl_q[2:0], byte_s};
                if (dl_cnt_q == 3'd4) begin
                    data_d  = dl_q[3];
                    valid_d = 1'b1;
                end else begin
                    dl_cnt_d = dl_cnt_q + 3'd1;
                end
            end else begin
                data_d  = byte_s;
                valid_d = 1'b1;
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge rx_clk) begin
        if (!rst_n) begin
            state_q      <= ST_RESYNC;
            mode_q       <= 1'b0;
            nib_have_q   <= 1'b0;
            nib_lo_q     <= 4'h0;
            crc_q        <= 32'hFFFFFFFF;
            cnt_q        <= {CNT_WIDTH{1'b0}};
            err_q        <= 1'b0;
            dl_q         <= 32'h00000000;
            dl_cnt_q     <= 3'd0;
            data_q       <= 8'h00;
            valid_q      <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            crc_ok_q     <= 1'b0;
            len_err_q    <= 1'b0;
            err_out_q    <= 1'b0;
            frame_len_q  <= {CNT_WIDTH{1'b0}};
            link_up_q    <= 1'b0;
            link_speed_q <= 2'b00;
            link_fdx_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            nib_have_q   <= nib_have_d;
            nib_lo_q     <= nib_lo_d;
            crc_q        <= crc_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            dl_q         <= dl_d;
            dl_cnt_q     <= dl_cnt_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
            crc_ok_q     <= crc_ok_d;
            len_err_q    <= len_err_d;
            err_out_q    <= err_out_d;
            frame_len_q  <= frame_len_d;
            link_up_q    <= link_up_d;
            link_speed_q <= link_speed_d;
            link_fdx_q   <= link_fdx_d;
        end
    end

    assign rx_out.data      = data_q;
    assign rx_out.valid     = valid_q;
    assign rx_out.sop       = sop_q;
    assign rx_out.eop       = eop_q;
    assign rx_out.crc_ok    = crc_ok_q;
    assign rx_out.len_err   = len_err_q;
    assign rx_out.err       = err_out_q;
    assign rx_out.frame_len = frame_len_q;
    assign link_up          = link_up_q;
    assign link_speed       = link_speed_q;
    assign link_fdx         = link_fdx_q;
endmodule

// File: tb/tb_eth_rgmii_rx_mr.sv
// Bench for eth_rgmii_rx_mr: one pass-through and one FCS-stripping instance share
// the stimulus; a scoreboard queues expected bytes/status and monitors pop them.
module tb_eth_rgmii_rx_mr;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] speed;
    logic       rx_dv;
    logic       rx_err;
    logic [7:0] rx_data;
    logic       link_up_a, link_fdx_a, link_up_b, link_fdx_b;
    logic [1:0] link_speed_a, link_speed_b;

    always #4 clk = ~clk;

    eth_rgmii_rx_mr_if #(.CNT_WIDTH(16)) if_a ();
    eth_rgmii_rx_mr_if #(.CNT_WIDTH(16)) if_b ();

    eth_rgmii_rx_mr #(.STRIP_FCS(0)) dut_a (
        .rx_clk(clk), .rst_n(rst_n), .speed(speed), .rx_dv(rx_dv), .rx_err(rx_err),
        .rx_data(rx_data), .rx_out(if_a), .link_up(link_up_a),
        .link_speed(link_speed_a), .link_fdx(link_fdx_a)
    );

    eth_rgmii_rx_mr #(.STRIP_FCS(1)) dut_b (
        .rx_clk(clk), .rst_n(rst_n), .speed(speed), .rx_dv(rx_dv), .rx_err(rx_err),
        .rx_data(rx_data), .rx_out(if_b), .link_up(link_up_b),
        .link_speed(link_speed_b), .link_fdx(link_fdx_b)
    );

    int          n_vec  = 0;
    int          n_fail = 0;
    logic [7:0]  exp_a[$];
    logic [7:0]  exp_b[$];
    logic [18:0] stat_a[$];   // {crc_ok, len_err, err, frame_len}
    logic [18:0] stat_b[$];
    int          exp_sop = 0;
    int          sop_a   = 0;
    int          sop_b   = 0;
    bit          nib_chk = 1'b0;
    logic        prev_a  = 1'b0;
    logic        prev_b  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference FCS: MSB-first shift register with polynomial 0x04C11DB7, fed LSB-first.
    function automatic logic [31:0] fcs_calc(input logic [7:0] m[$]);
        logic [31:0] c;
        logic [31:0] r;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (m[j]) begin
            for (int i = 0; i < 8; i++) begin
                fb = c[31] ^ m[j][i];
                c  = {c[30:0], 1'b0};
                if (fb) c = c ^ 32'h04C11DB7;
            end
        end
        for (int i = 0; i < 32; i++) r[i] = c[31-i];
        return ~r;
    endfunction

    // Scoreboard side: pop expectations when either instance produces output.
    always @(negedge clk) begin
        logic [18:0] s;
        logic [7:0]  e;
        if (if_a.sop) sop_a++;
        if (if_b.sop) sop_b++;
        if (if_a.valid) begin
            if (exp_a.size() == 0) chk("a_extra_valid", 32'd1, 32'd0);
            else begin
                e = exp_a.pop_front();
                chk("a_data", 32'(if_a.data), 32'(e));
            end
            if (nib_chk) chk("a_nib_spacing", 32'(prev_a), 32'd0);
        end
        if (if_b.valid) begin
            if (exp_b.size() == 0) chk("b_extra_valid", 32'd1, 32'd0);
            else begin
                e = exp_b.pop_front();
                chk("b_data", 32'(if_b.data), 32'(e));
            end
            if (nib_chk) chk("b_nib_spacing", 32'(prev_b), 32'd0);
        end
        if (if_a.eop) begin
            chk("a_eop_with_valid", 32'(if_a.valid), 32'd0);
            chk("a_eop_bytes_left", 32'(exp_a.size()), 32'd0);
            if (stat_a.size() == 0) chk("a_extra_eop", 32'd1, 32'd0);
            else begin
                s = stat_a.pop_front();
                chk("a_status", 32'({if_a.crc_ok, if_a.len_err, if_a.err, if_a.frame_len}), 32'(s));
                if (s[15:0] != 16'd0 && !s[16]) chk("a_eop_after_last", 32'(prev_a), 32'd1);
            end
        end
        if (if_b.eop) begin
            chk("b_eop_with_valid", 32'(if_b.valid), 32'd0);
            chk("b_eop_bytes_left", 32'(exp_b.size()), 32'd0);
            if (stat_b.size() == 0) chk("b_extra_eop", 32'd1, 32'd0);
            else begin
                s = stat_b.pop_front();
                chk("b_status", 32'({if_b.crc_ok, if_b.len_err, if_b.err, if_b.frame_len}), 32'(s));
                if (s[15:0] > 16'd4 && !s[16]) chk("b_eop_after_last", 32'(prev_b), 32'd1);
            end
        end
        prev_a = if_a.valid;
        prev_b = if_b.valid;
    end

    task automatic step(input logic dv, input logic er, input logic [7:0] d);
        @(posedge clk);
        #1;
        rx_dv   = dv;
        rx_err  = er;
        rx_data = d;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_frame(input int n_pay, input logic [1:0] spd, input bit with_fcs,
                              input int err_idx, input bit odd_nib);
        logic [7:0]  fr[$];
        logic [31:0] fcs;
        logic [18:0] st;
        bit          nib;
        int          len;
        nib = (spd == 2'b00) || (spd == 2'b01);
        for (int i = 0; i < n_pay; i++) fr.push_back(8'((i * 37 + 11) ^ (i >> 3)));
        if (with_fcs) begin
            fcs = fcs_calc(fr);
            for (int k = 0; k < 4; k++) fr.push_back(fcs[8*k +: 8]);
        end
        len = fr.size();
        foreach (fr[i]) exp_a.push_back(fr[i]);
        for (int i = 0; i < len - 4; i++) exp_b.push_back(fr[i]);
        st = {with_fcs, (len < 64 || len > 1518), ((err_idx >= 0) || odd_nib), 16'(len)};
        stat_a.push_back(st);
        stat_b.push_back(st);
        exp_sop++;
        nib_chk = nib;
        speed   = spd;
        if (nib) begin
            for (int i = 0; i < 15; i++) begin
                step(1'b1, 1'b0, 8'h35);
                if (i == 2) speed = 2'b10;   // must be ignored: mode is latched
            end
            step(1'b1, 1'b0, 8'h3D);
        end else begin
            repeat (7) step(1'b1, 1'b0, 8'h55);
            step(1'b1, 1'b0, 8'hD5);
        end
        foreach (fr[i]) begin
            if (nib) begin
                step(1'b1, (i == err_idx), {4'h3, fr[i][3:0]});
                step(1'b1, (i == err_idx), {4'h3, fr[i][7:4]});
            end else begin
                step(1'b1, (i == err_idx), fr[i]);
            end
        end
        if (odd_nib) step(1'b1, 1'b0, 8'h0A);
        idle(12);
        nib_chk = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        rx_dv   = 1'b0;
        rx_err  = 1'b0;
        rx_data = 8'h00;
        speed   = 2'b10;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("a_reset_out", 32'({if_a.data, if_a.valid, if_a.sop, if_a.eop, if_a.crc_ok, if_a.len_err, if_a.err}), 32'd0);
        chk("b_reset_out", 32'({if_b.data, if_b.valid, if_b.sop, if_b.eop, if_b.crc_ok, if_b.len_err, if_b.err}), 32'd0);
        chk("a_reset_len", 32'(if_a.frame_len), 32'd0);
        chk("a_reset_link", 32'({link_up_a, link_speed_a, link_fdx_a}), 32'd0);
        step(1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;
        idle(4);

        // 1G and 100M good frames, 64 bytes including FCS.
        send_frame(60, 2'b10, 1'b1, -1, 1'b0);
        send_frame(60, 2'b01, 1'b1, -1, 1'b0);

        // rx_err inside a frame, then an oversize frame with a good FCS.
        send_frame(60, 2'b10, 1'b1, 10, 1'b0);
        send_frame(1515, 2'b10, 1'b1, -1, 1'b0);

        // Bad preamble symbol: dropped after sop, no valid or eop.
        exp_sop++;
        speed = 2'b10;
        step(1'b1, 1'b0, 8'h55);
        step(1'b1, 1'b0, 8'h57);
        repeat (5) step(1'b1, 1'b0, 8'hD5);
        idle(8);

        // 10M frame with a dangling odd nibble.
        send_frame(60, 2'b00, 1'b1, -1, 1'b1);

        // In-band link status, then rx_err must block updates.
        repeat (3) step(1'b0, 1'b0, 8'h0B);
        @(negedge clk);
        chk("a_link_b", 32'({link_up_a, link_speed_a, link_fdx_a}), 32'hB);
        chk("b_link_b", 32'({link_up_b, link_speed_b, link_fdx_b}), 32'hB);
        repeat (2) step(1'b0, 1'b0, 8'h00);
        repeat (3) step(1'b0, 1'b1, 8'h0B);
        @(negedge clk);
        chk("a_link_err_hold", 32'({link_up_a, link_speed_a, link_fdx_a}), 32'h0);
        idle(2);

        // Reset mid-frame while rx_dv stays high, then receiver must resync.
        exp_sop++;
        speed = 2'b10;
        repeat (3) step(1'b1, 1'b0, 8'h55);
        rst_n = 1'b0;
        repeat (2) step(1'b1, 1'b0, 8'h55);
        rst_n = 1'b1;
        @(negedge clk);
        chk("a_midrst_status", 32'({if_a.crc_ok, if_a.err, if_a.frame_len}), 32'd0);
        chk("b_midrst_status", 32'({if_b.crc_ok, if_b.err, if_b.frame_len}), 32'd0);
        step(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 8'(i + 1));
        idle(6);
        send_frame(60, 2'b10, 1'b1, -1, 1'b0);

        // Zero-byte frame: SFD immediately followed by rx_dv=0.
        send_frame(0, 2'b10, 1'b0, -1, 1'b0);

        idle(10);
        chk("a_bytes_pending", 32'(exp_a.size()), 32'd0);
        chk("b_bytes_pending", 32'(exp_b.size()), 32'd0);
        chk("a_eops_pending", 32'(stat_a.size()), 32'd0);
        chk("b_eops_pending", 32'(stat_b.size()), 32'd0);
        chk("a_sop_count", 32'(sop_a), 32'(exp_sop));
        chk("b_sop_count", 32'(sop_b), 32'(exp_sop));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/eth_rgmii_rx_mr.md
Name: eth_rgmii_rx_mr

Overview:
- Multi-rate (10/100/1000) RGMII receive framer; successor to the 1G-only receiver.
- Consumes decoded RGMII signals from the existing glue (rx_dv, rx_err, 8-bit DDR-sampled data), all in the rx_clk domain.
- Adds nibble assembly for 10/100, length checking, optional FCS stripping, rx_err tracking and RGMII in-band link status.
- Emits a byte stream with sop/eop and per-frame status to the MAC rx FIFO.

Parameters:
- MIN_LEN, 64, minimum legal frame length in bytes (SFD excluded, FCS included).
- MAX_LEN, 1518, maximum legal frame length in bytes.
- CNT_WIDTH, 16, width of the frame byte counter; the counter saturates.
- STRIP_FCS, 0, when 1 the last 4 bytes (FCS) are never presented with valid=1.
- INBAND_STATUS, 1, when 1 the in-band status registers are updated; when 0 they hold their reset values.

Ports:
- rx_clk, in, 1, RGMII receive clock: 125, 25 or 2.5 MHz.
- rst_n, in, 1, reset. Active-low, synchronous to rx_clk.
- speed, in, 2, 2'b10 = 1000 (byte per clock), 2'b01 = 100 and 2'b00 = 10 (nibble per clock on rx_data[3:0]), 2'b11 treated as 1000.
- rx_dv, in, 1, decoded data valid from the glue.
- rx_err, in, 1, decoded receive error from the glue.
- rx_data, in, 8, decoded receive data from the glue.
- data, out, 8, frame byte.
- valid, out, 1, data holds a frame byte this cycle.
- sop, out, 1, one-cycle pulse at start of preamble.
- eop, out, 1, one-cycle pulse after the last byte.
- crc_ok, out, 1, CRC-32 residue was 0xDEBB20E3; updated at eop.
- len_err, out, 1, frame length was outside [MIN_LEN, MAX_LEN]; updated at eop.
- err, out, 1, rx_err was seen inside the frame, or an odd nibble was left over; updated at eop.
- frame_len, out, CNT_WIDTH, bytes received after SFD, FCS included; updated at eop.
- link_up, out, 1, in-band status bit 0.
- link_speed, out, 2, in-band status bits [2:1].
- link_fdx, out, 1, in-band status bit 3.

Behaviour:
- Reset values: all outputs 0. State goes to RESYNC.
- All outputs are registered. data/valid appear 1 clock after the completing input byte, or after the second nibble in 10/100 mode.
- Mode: speed is latched into mode_q on the IDLE→PREAMBLE transition and held for the whole frame. Changes to speed mid-frame are ignored.
- Nibble assembly (10/100): low nibble first. The SFD is the nibble 0x5 followed by the nibble 0xD. After SFD, bytes are formed as {nib1, nib0}, and valid pulses at most every 2nd clock.
- States:
  - RESYNC: wait for rx_dv=0, then go to IDLE. This prevents capturing from mid-frame after reset.
  - IDLE:
    - rx_dv=1 and first symbol is 0x55 (1G) or 0x5 (10/100): go to PREAMBLE, pulse sop, clear the CRC and the byte count.
    - rx_dv=1 with any other first symbol: go to DROP.
    - rx_dv=0 and rx_err=0 and INBAND_STATUS=1: register link_up/link_speed/link_fdx from rx_data[3:0] every such cycle.
  - PREAMBLE:
    - Continues while the symbol is 0x55 or 0x5.
    - 0xD5 (1G), or the nibble 0xD immediately after a 0x5 (10/100): go to PACKET.
    - Any other symbol: go to DROP.
    - rx_dv=0: go to IDLE with no eop.
  - PACKET:
    - For each completed byte: update the CRC, increment the count (saturating at 2^CNT_WIDTH-1) and emit the byte.
    - rx_err=1 while rx_dv=1 sets the sticky err_q flag.
    - On rx_dv=0: pulse eop and register crc_ok, len_err, err and frame_len; go to IDLE.
    - A dangling odd nibble at rx_dv=0 is discarded and sets err.
  - DROP: wait for rx_dv=0, then go to IDLE. No valid, no eop.
- STRIP_FCS=1:
  - Bytes pass through a 4-deep byte delay line.
  - The first 4 bytes of a frame do not produce valid.
  - The 4 bytes in the delay line at eop are discarded.
  - frame_len still includes the FCS.
  - Frames shorter than 4 bytes produce eop with no valid bytes.
- eop coincides with the cycle after the last valid, never the same cycle.
- A frame of zero bytes (SFD then rx_dv=0) produces eop with frame_len=0, len_err=1 and crc_ok=0.
- rst_n=0 mid-frame: outputs clear on the next clock with no eop. State goes to RESYNC.

Test Plan:
- 1G, speed=2'b10, 7×0x55, 0xD5, 60-byte payload plus correct FCS → sop once, 64 valid bytes, eop the next cycle, crc_ok=1, len_err=0, err=0, frame_len=64.
- Same frame at speed=2'b01 as nibbles (low first) → valid every 2nd clock, identical bytes, crc_ok=1, frame_len=64.
- STRIP_FCS=1 with the 64-byte frame → 60 valid bytes, crc_ok=1, frame_len=64.
- 1G frame with rx_err=1 on byte 10, plus a 1519-byte frame → first: err=1; second: len_err=1, crc_ok=1.
- Preamble 0x55, 0x57 → DROP, no valid, no eop until rx_dv=0. Then a 10/100 frame ending on an odd nibble → eop with err=1.
- Idle with rx_dv=0, rx_err=0, rx_data=4'hB → link_up=1, link_speed=2'b01, link_fdx=1. rst_n=0 mid-frame with rx_dv held high → no output until rx_dv=0, then the next frame is received normally.
